// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg
// Shared types and constants for the USB transmit serializer.
//   tx_state_t          : serializer FSM states
//   SYNC_BYTE           : SYNC pattern, sent LSB first (KJKJKJKK)
//   STUFF_LIMIT         : run of ones that forces a stuffed zero
//   LINE_J/LINE_K/SE0   : {dplus, dminus} line encodings
//   level_to_line()     : maps an NRZI level (1 = J) to a line pair
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;

    // Line pair ordering is {dplus, dminus}
    typedef logic [1:0] line_t;
    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_SE0 = 2'b00;

    function automatic line_t level_to_line(input logic level);
        return level ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// flex_pts_sr
// Parameterised parallel-to-serial shift register.
//   clk, n_rst     : clock, asynchronous active-low reset
//   load_enable    : capture parallel_in (has priority over shifting)
//   shift_enable   : advance one bit toward serial_out
//   parallel_in    : NUM_BITS word to serialise
//   serial_out     : bit currently presented (LSB when SHIFT_LSB = 1)
module flex_pts_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_LSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] shift_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q <= '0;
        end else if (load_enable) begin
            shift_q <= parallel_in;
        end else if (shift_enable) begin
            if (SHIFT_LSB) begin
                shift_q <= {1'b0, shift_q[NUM_BITS-1:1]};
            end else begin
                shift_q <= {shift_q[NUM_BITS-2:0], 1'b0};
            end
        end
    end

    assign serial_out = SHIFT_LSB ? shift_q[0] : shift_q[NUM_BITS-1];

endmodule

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer
// Turns a byte stream into a USB low-level NRZI bit stream with SYNC,
// optional bit stuffing and EOP. One holding register feeds an 8-bit
// shift register so consecutive bytes go out with no gap.
//   clk, n_rst              : clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_last: byte input, tx_last marks packet end
//   tx_ready                : holding register can take a byte
//   dplus_out/dminus_out    : line drive (J = 10, K = 01, SE0 = 00)
//   tx_busy                 : packet in progress (non-IDLE)
//   tx_underrun             : one-cycle pulse when a non-last byte ends
//                             with nothing queued behind it
// Build option: define USB_TX_BITSTUFF_EN to enable bit stuffing; when
// undefined, data is sent as raw NRZI (line test mode).
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_underrun
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t     state, next_state;
    logic [TW-1:0] bit_timer;
    logic          bit_end;
    logic [2:0]    bit_cnt;
    logic [7:0]    hold_data;
    logic          hold_last, hold_full;
    logic          cur_last, prev_level;
    logic          cur_bit, cur_level;
    logic          sr_load, sr_shift, load_from_hold, sr_out;
    logic [7:0]    sr_load_data;
    logic          accept, underrun_set, stuff_needed;
    line_t         line;

    assign accept         = tx_valid && tx_ready;
    assign bit_end        = (bit_timer == TW'(CLKS_PER_BIT - 1));
    assign cur_bit        = (state == STUFF) ? 1'b0 : sr_out;
    // NRZI: a zero flips the line, a one holds it
    assign cur_level      = cur_bit ? prev_level : ~prev_level;
    assign sr_load_data   = (state == IDLE) ? SYNC_BYTE : hold_data;
    assign load_from_hold = sr_load && (state != IDLE);

    flex_pts_sr #(
        .NUM_BITS (8),
        .SHIFT_LSB(1'b1)
    ) u_shift (
        .clk         (clk),
        .n_rst       (n_rst),
        .load_enable (sr_load),
        .shift_enable(sr_shift),
        .parallel_in (sr_load_data),
        .serial_out  (sr_out)
    );

`ifdef USB_TX_BITSTUFF_EN
    logic [2:0] ones_cnt;
    logic       eop_pending;

    // A stuff bit is due once this one would make STUFF_LIMIT ones in a row
    assign stuff_needed = cur_bit && (ones_cnt == 3'(STUFF_LIMIT - 1)) &&
                          ((state == SYNC) || (state == DATA));

    // Ones run spans SYNC and byte boundaries; eop_pending remembers that
    // the stuff bit in flight closes the final byte
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_cnt    <= '0;
            eop_pending <= 1'b0;
        end else if (state == IDLE) begin
            ones_cnt    <= '0;
            eop_pending <= 1'b0;
        end else if (bit_end) begin
            if ((state == STUFF) || !cur_bit || stuff_needed) begin
                ones_cnt <= '0;
            end else begin
                ones_cnt <= ones_cnt + 3'd1;
            end
            if (next_state == STUFF) begin
                eop_pending <= (state == DATA) && (bit_cnt == 3'd7) && cur_last;
            end
        end
    end
`else
    assign stuff_needed = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; shift/load decisions are made at the end of each bit
    always_comb begin
        next_state   = state;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        underrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    sr_load    = 1'b1;
                    next_state = SYNC;
                end
            end
            SYNC, DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        if (state == SYNC) begin
                            sr_load    = 1'b1;
                            next_state = DATA;
                        end else if (cur_last) begin
                            next_state = stuff_needed ? STUFF : EOP_SE0;
                        end else if (hold_full) begin
                            sr_load    = 1'b1;
                            next_state = stuff_needed ? STUFF : DATA;
                        end else begin
                            underrun_set = 1'b1;
                            next_state   = EOP_SE0;
                        end
                    end else begin
                        sr_shift   = 1'b1;
                        next_state = stuff_needed ? STUFF : state;
                    end
                end
            end
`ifdef USB_TX_BITSTUFF_EN
            STUFF: begin
                if (bit_end) begin
                    next_state = eop_pending ? EOP_SE0 : DATA;
                end
            end
`endif
            EOP_SE0: begin
                if (bit_end && (bit_cnt == 3'd1)) begin
                    next_state = EOP_J;
                end
            end
            EOP_J: begin
                if (bit_end) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs; a packet is closed to new bytes once its last byte is shifting
    always_comb begin
        line     = LINE_J;
        tx_busy  = 1'b1;
        tx_ready = !hold_full;
        case (state)
            IDLE: begin
                tx_busy = 1'b0;
            end
            SYNC: begin
                line = level_to_line(cur_level);
            end
            DATA, STUFF: begin
                line = level_to_line(cur_level);
                if (cur_last) begin
                    tx_ready = 1'b0;
                end
            end
            EOP_SE0: begin
                line     = LINE_SE0;
                tx_ready = 1'b0;
            end
            EOP_J: begin
                tx_ready = 1'b0;
            end
            default: ;
        endcase
    end

    assign dplus_out  = line[1];
    assign dminus_out = line[0];

    // Datapath: bit timer, bit counter (reused to time the two SE0 bits),
    // holding register and NRZI level
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_timer   <= '0;
            bit_cnt     <= '0;
            hold_data   <= '0;
            hold_last   <= 1'b0;
            hold_full   <= 1'b0;
            cur_last    <= 1'b0;
            prev_level  <= 1'b1;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= underrun_set;

            if ((state == IDLE) || bit_end) begin
                bit_timer <= '0;
            end else begin
                bit_timer <= bit_timer + 1'b1;
            end

            if (sr_load || ((next_state == EOP_SE0) && (state != EOP_SE0))) begin
                bit_cnt <= '0;
            end else if (sr_shift || ((state == EOP_SE0) && bit_end)) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (accept) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
            end else if (load_from_hold) begin
                hold_full <= 1'b0;
            end

            if (sr_load) begin
                cur_last <= load_from_hold ? hold_last : 1'b0;
            end

            if (state == IDLE) begin
                prev_level <= 1'b1;
            end else if (bit_end) begin
                prev_level <= cur_level;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer
// Scoreboarded bench for usb_tx_serializer (CLKS_PER_BIT = 8). Each
// packet pushes its hand-derived line symbol string (J, K, 0 = SE0) to a
// queue; a monitor pops it when tx_busy rises and checks every clock of
// every symbol, plus tx_busy and the tx_underrun pulse position.
// Expected strings follow USB_TX_BITSTUFF_EN the same way the design does.
module tb_usb_tx_serializer;

    localparam int CPB = 8;

    logic       clk;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_busy;
    logic       tx_underrun;

    int vectors    = 0;
    int miscompares = 0;
    bit mon_active = 0;

    string sb_syms[$];
    int    sb_ur[$];
    bit    sb_abort[$];

    usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .tx_busy    (tx_busy),
        .tx_underrun(tx_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic byte lineChar(input logic dp, input logic dm);
        case ({dp, dm})
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    task automatic pushExp(input string syms, input int ur_idx, input bit aborted);
        sb_syms.push_back(syms);
        sb_ur.push_back(ur_idx);
        sb_abort.push_back(aborted);
    endtask

    // Offer one byte and return the time of the accepting clock edge
    task automatic applyStimulus(input logic [7:0] data, input logic last, output time t_acc);
        bit got_it;
        got_it   = 0;
        t_acc    = 0;
        tx_data  = data;
        tx_last  = last;
        tx_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                got_it = 1;
                break;
            end
        end
        if (got_it) begin
            @(posedge clk);
            t_acc = $time;
        end else begin
            checkOutput("byte acceptance timeout", 0, 1);
        end
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sb_syms.size() == 0 && !mon_active && !tx_busy) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checkOutput({name, " completion timeout"}, 0, 1);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, " lines"}, int'({dplus_out, dminus_out}), 2);
        checkOutput({name, " tx_ready"}, int'(tx_ready), 1);
        checkOutput({name, " tx_busy"}, int'(tx_busy), 0);
        checkOutput({name, " tx_underrun"}, int'(tx_underrun), 0);
    endtask

    // Monitor: on each tx_busy rise, pop one expected packet and check it
    initial begin : monitor
        string exp_s;
        int    exp_ur;
        bit    exp_ab;
        byte   want, got, obs;
        bit    want_ur;
        bit    prev_busy;
        int    pkt_no;
        prev_busy = 0;
        pkt_no    = 0;
        forever begin
            @(negedge clk);
            if (n_rst && tx_busy && !prev_busy) begin
                if (sb_syms.size() == 0) begin
                    checkOutput("unexpected packet start", 1, 0);
                end else begin
                    exp_s  = sb_syms.pop_front();
                    exp_ur = sb_ur.pop_front();
                    exp_ab = sb_abort.pop_front();
                    mon_active = 1;
                    for (int s = 0; s < exp_s.len(); s++) begin
                        want = exp_s[s];
                        obs  = want;
                        for (int c = 0; c < CPB; c++) begin
                            if (s != 0 || c != 0) @(negedge clk);
                            got     = lineChar(dplus_out, dminus_out);
                            want_ur = (s == exp_ur) && (c == 0);
                            if (obs == want) begin
                                if (got != want) obs = got;
                                else if (!tx_busy) obs = "b";
                                else if (tx_underrun != want_ur) obs = "u";
                            end
                        end
                        checkOutput($sformatf("pkt%0d symbol%0d", pkt_no, s), int'(obs), int'(want));
                    end
                    if (!exp_ab) begin
                        @(negedge clk);
                        checkOutput($sformatf("pkt%0d idle after EOP", pkt_no),
                                    int'({tx_busy, dplus_out, dminus_out}), 2);
                    end else begin
                        for (int i = 0; i < 64 && tx_busy; i++) @(negedge clk);
                    end
                    pkt_no++;
                    mon_active = 0;
                end
            end
            prev_busy = tx_busy;
        end
    end

    // Stimulus
    initial begin : stimulus
        time t1, t2;
        n_rst    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        #3;
        checkIdleOutputs("reset");
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 0x00 last: eight toggles after SYNC
        $display("[TB] single byte 0x00");
        pushExp("KJKJKJKKJKJKJKJK00J", -1, 0);
        applyStimulus(8'h00, 1'b1, t1);
        waitIdle("0x00");

        // 0xFF last: the SYNC trailing one plus five data ones force a stuff
        $display("[TB] single byte 0xFF");
`ifdef USB_TX_BITSTUFF_EN
        pushExp("KJKJKJKKKKKKKJJJJ00J", -1, 0);
`else
        pushExp("KJKJKJKKKKKKKKKK00J", -1, 0);
`endif
        applyStimulus(8'hFF, 1'b1, t1);
        waitIdle("0xFF");

        // 0x3F then 0x01 back to back; second byte waits out SYNC
        $display("[TB] back-to-back 0x3F 0x01");
`ifdef USB_TX_BITSTUFF_EN
        pushExp("KJKJKJKKKKKKKJJKJJKJKJKJK00J", -1, 0);
`else
        pushExp("KJKJKJKKKKKKKKJKKJKJKJKJ00J", -1, 0);
`endif
        applyStimulus(8'h3F, 1'b0, t1);
        applyStimulus(8'h01, 1'b1, t2);
        checkOutput("second byte acceptance gap", int'((t2 - t1) / 10), 65);
        checkOutput("tx_ready with holding full", int'(tx_ready), 0);
        waitIdle("0x3F 0x01");

        // 0xFC then 0x00: six ones end exactly on the byte boundary
        $display("[TB] stuff on byte boundary 0xFC 0x00");
`ifdef USB_TX_BITSTUFF_EN
        pushExp("KJKJKJKKJKKKKKKKJKJKJKJKJ00J", -1, 0);
`else
        pushExp("KJKJKJKKJKKKKKKKJKJKJKJK00J", -1, 0);
`endif
        applyStimulus(8'hFC, 1'b0, t1);
        applyStimulus(8'h00, 1'b1, t2);
        waitIdle("0xFC 0x00");

        // 0xA5 not last and nothing behind it: underrun then EOP
        $display("[TB] underrun 0xA5");
        pushExp("KJKJKJKKKJJKJJKK00J", 16, 0);
        applyStimulus(8'hA5, 1'b0, t1);
        waitIdle("0xA5 underrun");

        // Reset partway through the third data bit of 0x55
        $display("[TB] reset mid-packet");
        pushExp("KJKJKJKKKJ", -1, 1);
        applyStimulus(8'h55, 1'b1, t1);
        repeat (83) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        checkIdleOutputs("mid-packet reset");
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        waitIdle("aborted packet");

        // Clean packet after the abort
        $display("[TB] packet after reset");
        pushExp("KJKJKJKKJKJKJKJK00J", -1, 0);
        applyStimulus(8'h00, 1'b1, t1);
        waitIdle("post-reset 0x00");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_tx_serializer.md
USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clk cycles per USB bit period (min 2).
REQ-002 SHALL have ports clk  input  1  clock; n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port tx_data  input  8  packet byte, transmitted LSB first.
REQ-004 SHALL have port tx_valid  input  1  tx_data valid.
REQ-005 SHALL have port tx_last  input  1  qualifies tx_data as final byte of packet.
REQ-006 SHALL have port tx_ready  output  1  byte accepted when tx_valid && tx_ready.
REQ-007 SHALL have ports dplus_out, dminus_out  output  1 each  NRZI line drive.
REQ-008 SHALL have port tx_busy  output  1  high from first byte acceptance until return to IDLE.
REQ-009 SHALL have port tx_underrun  output  1  one-cycle pulse on holding-register underrun.

Function
REQ-010 SHALL be double-buffered: one holding register (byte+last flag) feeding an 8-bit shift register; tx_ready = holding register empty.
REQ-011 SHALL use FSM states IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
REQ-012 IDLE: lines J (dplus=1, dminus=0); first accepted byte in cycle N moves to SYNC, first SYNC bit on lines from cycle N+1.
REQ-013 Every line symbol SHALL be held exactly CLKS_PER_BIT cycles; bit timer restarts on IDLE exit.
REQ-014 SYNC: block generates 8'h80 LSB first (KJKJKJKK); then DATA with first held byte.
REQ-015 NRZI: data 0 toggles J/K, data 1 holds current level.
REQ-016 Consecutive-ones counter SHALL count SYNC and data bits across byte boundaries, clear on any transmitted 0.
REQ-017 When counter reaches 6, next bit period SHALL be STUFF (transmitted 0), counter cleared, shift register paused.
REQ-018 On last bit of a byte: holding register full -> load it with no gap; holding empty and byte not last -> tx_underrun pulse, go EOP_SE0.
REQ-019 After last bit (or pending stuff bit) of a tx_last byte -> EOP_SE0 (both lines 0) 2 bit periods, EOP_J 1 bit period, then IDLE.
REQ-020 tx_ready SHALL be low in EOP_SE0/EOP_J; bytes cannot start a new packet until IDLE.
REQ-021 Simultaneous shift-register load and new acceptance in same cycle SHALL be supported (holding stays full).

Reset
REQ-022 Reset SHALL force IDLE, lines J, tx_ready=1, tx_busy=0, tx_underrun=0, holding empty, counters 0.
REQ-023 Reset mid-packet SHALL abort immediately; no EOP emitted.

Configuration
REQ-024 Macro USB_TX_BITSTUFF_EN defined: stuffing per REQ-016/017.
REQ-025 USB_TX_BITSTUFF_EN undefined: STUFF state and ones counter omitted; raw NRZI of data only (line test mode).

Structure
REQ-026 Package usb_tx_pkg SHALL hold state enum, SYNC_BYTE=8'h80, STUFF_LIMIT=6, J/K/SE0 line encodings.
REQ-027 Sub-module flex_pts_sr (parameterised parallel-to-serial shift register, load + shift_enable, LSB-first option) SHALL implement the shift register.

Verification (CLKS_PER_BIT=8)
REQ-028 Single byte 0x00, last -> SYNC, 8 alternating toggles, SE0 16 clk, J 8 clk; 19 bit periods = 152 clk, tx_busy high throughout.
REQ-029 Single byte 0xFF, last -> stuffed 0 after 5th data bit (SYNC trailing 1 counts); 20 bit periods = 160 clk.
REQ-030 Bytes 0x3F,0x01 back-to-back (second last) -> stuff across boundary after 0x3F bit 5; no gap between bytes; tx_ready low only while holding full.
REQ-031 Byte 0xA5 not last, no follow-up -> tx_underrun one pulse after 8th data bit, then EOP, IDLE.
REQ-032 n_rst low mid-DATA -> lines J same cycle, tx_ready=1, tx_busy=0; next packet starts cleanly with SYNC.
REQ-033 USB_TX_BITSTUFF_EN undefined, byte 0xFF last -> no stuff bit; 19 bit periods.
